// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  localparam int SHA_WORD_W  = 32;
  localparam int SHA_BLOCK_W = 512;
  localparam int SHA_WORDS   = 16;
  localparam int SHA_LEN_W   = 64;
  localparam logic [SHA_WORD_W-1:0] SHA_PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    FILL,
    FLUSH,
    EXTRA
  } pad_state_e;

  // Big-endian bit length: high half in word 14, low half in word 15.
  function automatic logic [SHA_BLOCK_W-1:0] put_len(input logic [SHA_BLOCK_W-1:0] blk,
                                                     input logic [SHA_LEN_W-1:0]   len);
    logic [SHA_BLOCK_W-1:0] r;
    r = blk;
    r[14*SHA_WORD_W +: SHA_WORD_W] = len[63:32];
    r[15*SHA_WORD_W +: SHA_WORD_W] = len[31:0];
    return r;
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Word-stream input and block output bundle of the SHA-256 padder.
// in_bytes exists only when SHA256_PAD_BYTE_EN is defined.
interface sha256_padder_if;
  import sha256_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [SHA_WORD_W-1:0]  in_data;
  logic                   in_last;
`ifdef SHA256_PAD_BYTE_EN
  logic [1:0]             in_bytes;
`endif
  logic                   out_valid;
  logic [SHA_BLOCK_W-1:0] out_block;
  logic                   out_last;

`ifdef SHA256_PAD_BYTE_EN
  modport master (output in_valid, in_data, in_last, in_bytes,
                  input  in_ready, out_valid, out_block, out_last);
  modport slave  (input  in_valid, in_data, in_last, in_bytes,
                  output in_ready, out_valid, out_block, out_last);
`else
  modport master (output in_valid, in_data, in_last,
                  input  in_ready, out_valid, out_block, out_last);
  modport slave  (input  in_valid, in_data, in_last,
                  output in_ready, out_valid, out_block, out_last);
`endif

endinterface

// File: rtl/sha256_pad_word.sv
// Inserts the 0x80 pad byte into a partial last word (SHA256_PAD_BYTE_EN);
// full words pass through unchanged and flag that the pad goes to the next word.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [SHA_WORD_W-1:0] word,
`ifdef SHA256_PAD_BYTE_EN
  input  logic [1:0]            nbytes,
`endif
  output logic [SHA_WORD_W-1:0] pad_word,
  output logic                  full
);

`ifdef SHA256_PAD_BYTE_EN
  always_comb begin
    pad_word = word;
    full     = 1'b0;
    unique case (nbytes)
      2'd1:    pad_word = {word[31:24], 8'h80, 16'h0000};
      2'd2:    pad_word = {word[31:16], 8'h80, 8'h00};
      2'd3:    pad_word = {word[31:8], 8'h80};
      default: full     = 1'b1;
    endcase
  end
`else
  assign pad_word = word;
  assign full     = 1'b1;
`endif

endmodule

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs 32-bit words into 512-bit blocks for sha256_512top.
// Optional SHA256_PAD_BYTE_EN adds byte-granular last words via in_bytes.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  sha256_padder_if.slave  bus
);

  pad_state_e             state, state_nxt;
  logic [3:0]             widx, widx_nxt;
  logic [SHA_LEN_W-1:0]   len, len_nxt, len_inc, len_sum;
  logic                   extra_q, extra_nxt, carry_q, carry_nxt;
  logic                   vld_p1, vld_nxt, last_p1, last_nxt;
  logic [SHA_BLOCK_W-1:0] blk_p1, blk_nxt;
  logic [SHA_WORD_W-1:0]  words_q [SHA_WORDS];
  logic                   xfer, words_we;
  logic [SHA_WORD_W-1:0]  pad_word;
  logic                   pad_full, need_extra;
  logic [4:0]             pad_pos;
  logic [SHA_BLOCK_W-1:0] flush_blk, full_blk, extra_blk;

  assign bus.in_ready  = (state == FILL) && !rst;
  assign xfer          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_block = blk_p1;

  sha256_pad_word u_pad_word (
    .word     (bus.in_data),
`ifdef SHA256_PAD_BYTE_EN
    .nbytes   (bus.in_bytes),
`endif
    .pad_word (pad_word),
    .full     (pad_full)
  );

`ifdef SHA256_PAD_BYTE_EN
  assign len_inc = (bus.in_last && !pad_full) ? {59'd0, bus.in_bytes, 3'd0} : 64'd32;
`else
  assign len_inc = 64'd32;
`endif
  assign len_sum    = len + len_inc;
  assign pad_pos    = {1'b0, widx} + {4'd0, pad_full};
  assign need_extra = pad_pos > 5'd13;

  // Words beyond the last index are forced to zero, so stale buffer data never leaks.
  always_comb begin
    flush_blk = '0;
    full_blk  = '0;
    for (int i = 0; i < SHA_WORDS; i++) begin
      full_blk[SHA_WORD_W*i +: SHA_WORD_W] = words_q[i];
      if (4'(i) < widx)
        flush_blk[SHA_WORD_W*i +: SHA_WORD_W] = words_q[i];
      else if (4'(i) == widx)
        flush_blk[SHA_WORD_W*i +: SHA_WORD_W] = pad_word;
      else if (pad_full && (5'(i) == pad_pos))
        flush_blk[SHA_WORD_W*i +: SHA_WORD_W] = SHA_PAD_WORD;
    end
    full_blk[15*SHA_WORD_W +: SHA_WORD_W] = bus.in_data;
    if (!need_extra)
      flush_blk = put_len(flush_blk, len_sum);
    extra_blk = '0;
    extra_blk[SHA_WORD_W-1:0] = carry_q ? SHA_PAD_WORD : '0;
    extra_blk = put_len(extra_blk, len);
  end

  always_comb begin
    state_nxt = state;
    widx_nxt  = widx;
    len_nxt   = len;
    extra_nxt = extra_q;
    carry_nxt = carry_q;
    vld_nxt   = 1'b0;
    last_nxt  = 1'b0;
    blk_nxt   = blk_p1;
    words_we  = 1'b0;
    unique case (state)
      FILL: begin
        if (xfer) begin
          len_nxt = len_sum;
          if (bus.in_last) begin
            vld_nxt   = 1'b1;
            blk_nxt   = flush_blk;
            last_nxt  = !need_extra;
            extra_nxt = need_extra;
            carry_nxt = pad_full && (widx == 4'd15);
            state_nxt = FLUSH;
          end else begin
            words_we = 1'b1;
            widx_nxt = widx + 4'd1;
            if (widx == 4'd15) begin
              vld_nxt = 1'b1;
              blk_nxt = full_blk;
            end
          end
        end
      end
      FLUSH: begin
        if (extra_q) begin
          vld_nxt   = 1'b1;
          blk_nxt   = extra_blk;
          last_nxt  = 1'b1;
          state_nxt = EXTRA;
        end else begin
          widx_nxt  = '0;
          len_nxt   = '0;
          state_nxt = FILL;
        end
      end
      EXTRA: begin
        widx_nxt  = '0;
        len_nxt   = '0;
        state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Stage p1: registered block output and control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      widx    <= '0;
      len     <= '0;
      extra_q <= 1'b0;
      carry_q <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      blk_p1  <= '0;
    end else begin
      state   <= state_nxt;
      widx    <= widx_nxt;
      len     <= len_nxt;
      extra_q <= extra_nxt;
      carry_q <= carry_nxt;
      vld_p1  <= vld_nxt;
      last_p1 <= last_nxt;
      blk_p1  <= blk_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (words_we)
      words_q[widx] <= bus.in_data;
  end

endmodule
